// File: rtl/skylark_pkg.sv
// rtl/skylark_pkg.sv - shared types and constants for the unified-memory arbiter
package skylark_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    localparam int DEFAULT_MEM_LATENCY = 2;

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - loadable latency down-counter that saturates at zero
module mem_wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    // Load takes priority; decrement stops at zero so the count never wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the single-port unified memory
module mem_arbiter
    import skylark_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    arb_state_t state;
    owner_t     owner;
    owner_t     last_grant;
    logic       we_q;
    logic       cnt_zero;
    logic       grant_data;

    // Data normally wins; fetch wins when data took the previous grant and fetch is waiting
    assign grant_data = dm_req & ~((last_grant == OWN_DATA) & if_req);

    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    mem_wait_counter #(
        .WIDTH(CW)
    ) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ARB_ACCESS),
        .dec      (state == ARB_WAIT),
        .load_val (CNT_LOAD),
        .zero     (cnt_zero)
    );

    // Arbitration FSM with registered memory strobe, responses and valid pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= OWN_FETCH;
            last_grant <= OWN_FETCH;
            we_q       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            if_rdata   <= 32'd0;
            dm_rdata   <= 32'd0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (if_req || dm_req) begin
                        owner     <= grant_data ? OWN_DATA : OWN_FETCH;
                        we_q      <= grant_data & dm_we;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_data & dm_we;
                        mem_addr  <= grant_data ? dm_addr : if_addr;
                        mem_wdata <= grant_data ? dm_wdata : 32'd0;
                        state     <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    state <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (cnt_zero) begin
                        if (owner == OWN_FETCH) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            if (!we_q) begin
                                dm_rdata <= mem_rdata;
                            end
                            dm_valid <= 1'b1;
                        end
                        last_grant <= owner;
                        state      <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
